peripheral_ahb3_slave_mem: RTL

AHB3-Lite slave memory that attaches directly to one slave port of the multi-master AHB3 interconnect. It consumes the interconnect's slv_* outputs, drives HRDATA/HREADYOUT/HRESP back, and serves as the on-chip scratch RAM and bus-verification target for the MSI fabric. It supports byte, halfword, word and dword accesses, programmable wait states, write-to-read forwarding and a two-cycle ERROR response.

---
 rtl/peripheral_ahb3_pkg.sv | 25 ++
 rtl/peripheral_ahb3_mem_ram.sv | 49 ++++
 rtl/peripheral_ahb3_slave_mem.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the slave-memory data-phase state type.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

endpackage

// File: rtl/peripheral_ahb3_mem_ram.sv
// DEPTH x XLEN RAM with byte-lane writes and a registered, write-first read.
module peripheral_ahb3_mem_ram #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN/8-1:0] wbe,
    input  logic [XLEN-1:0]   wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [XLEN-1:0]   rdata
);
    localparam int BYTES = XLEN / 8;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rdata_q, rdata_d;

    // NOTE: the storage array has no reset; only the read register does.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Lanes committed on this edge to the word being read are merged in.
    always_comb begin
        rd_word = mem[raddr];
        for (int b = 0; b < BYTES; b++) begin
            if (we && wbe[b] && (waddr == raddr)) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
        end
        rdata_d = re ? rd_word : rdata_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/peripheral_ahb3_slave_mem.sv
// AHB3-Lite scratch-RAM slave: sized accesses, wait states, W->R forwarding, two-cycle ERROR.
module peripheral_ahb3_slave_mem
    import peripheral_ahb3_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int PLEN        = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            HRESETn,
    input  logic            HCLK,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);
    localparam int BYTES = XLEN / 8;
    localparam int BB    = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    ahb_state_e       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             pend_wr_q, pend_wr_d;
    logic [AW-1:0]    dp_word_q, dp_word_d;
    logic [BYTES-1:0] dp_be_q, dp_be_d;

    logic             accept, addr_err;
    logic [PLEN-BB-1:0] req_word;
    logic [BB-1:0]    lo_mask;
    logic [BYTES-1:0] req_be;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_raddr;
    logic             unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    assign req_word = HADDR[PLEN-1:BB];
    assign lo_mask  = BB'((32'd1 << HSIZE) - 32'd1);
    assign addr_err = (HSIZE > 3'(BB))
                    || (|(HADDR[BB-1:0] & lo_mask))
                    || (|(req_word >> AW));

    // Address phases are only taken while this slave can be driving HREADYOUT high.
    assign accept = HSEL && HREADY
                  && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
                  && (state_q != ST_WAIT) && (state_q != ST_ERR1);

    always_comb begin
        req_be = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= int'(HADDR[BB-1:0]) && b < int'(HADDR[BB-1:0]) + (1 << HSIZE))
                req_be[b] = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pend_wr_d = pend_wr_q;
        dp_word_d = dp_word_q;
        dp_be_d   = dp_be_q;

        if (state_q == ST_DATA) pend_wr_d = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 4'd0) state_d = ST_DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (addr_err) begin
                state_d = ST_ERR1;
            end else begin
                state_d   = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                wcnt_d    = WS_LOAD;
                pend_wr_d = HWRITE;
                dp_word_d = req_word[AW-1:0];
                dp_be_d   = req_be;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            pend_wr_q <= 1'b0;
            dp_word_q <= '0;
            dp_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            pend_wr_q <= pend_wr_d;
            dp_word_q <= dp_word_d;
            dp_be_q   <= dp_be_d;
        end
    end

    // Zero-wait reads sample the RAM at acceptance; otherwise in the last WAIT cycle.
    assign ram_we    = (state_q == ST_DATA) && pend_wr_q;
    assign ram_re    = (WAIT_STATES == 0)
                     ? (accept && !addr_err && !HWRITE)
                     : ((state_q == ST_WAIT) && (wcnt_q == 4'd0) && !pend_wr_q);
    assign ram_raddr = (WAIT_STATES == 0) ? req_word[AW-1:0] : dp_word_q;

    peripheral_ahb3_mem_ram #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (HCLK),
        .rst_n(HRESETn),
        .we   (ram_we),
        .waddr(dp_word_q),
        .wbe  (dp_be_q),
        .wdata(HWDATA),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(HRDATA)
    );

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule
